uart_frame_tx: RTL
==================

# uart_frame_tx

Buffered asynchronous serial transmitter for the interface board's PC link, the transmit counterpart of the 8-bit UART receive path on the same CLK domain. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each one onto TX as an LSB-first frame: start bit, data bits, optional parity, stop bit(s). The default baud divider gives 9600 baud from the 50 MHz board clock. The FIFO lets upper logic burst a short reply without waiting per byte.

## Interface
- CLKS_PER_BIT, 5208: CLK cycles per serial bit, legal range 4..65535.
- FIFO_DEPTH, 4: FIFO entries, power of two, 2..16.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- PARITY_ODD, 0: parity sense, 1 = odd, 0 = even. Used only when the parity macro is defined.
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- TX_DATA  in  8  byte to send.
- TX_VALID  in  1  TX_DATA is valid this cycle.
- TX_READY  out  1  FIFO can accept a byte. Combinational: high when the FIFO count is below FIFO_DEPTH.
- TX  out  1  serial line, registered, idle high.
- BUSY  out  1  registered. High from the start bit through the last stop bit, and while the FIFO is non-empty.
- FIFO_COUNT  out  5  entries currently stored.

## Operation
- Push: on a CLK edge where TX_VALID and TX_READY are both high, TX_DATA is written to the FIFO.
- When TX_VALID is high and TX_READY is low, the input is ignored. The source must hold TX_DATA until it is accepted.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE:
  - TX = 1.
  - If the FIFO is non-empty, pop the head byte into the shift register, clear the baud counter, drive TX = 0 and go to START.
- START, DATA, PARITY, STOP each hold TX for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on every bit transition.
- DATA: shift out 8 bits LSB first. A 3-bit counter drives exit to PARITY, or to STOP when parity is compiled out.
- PARITY: TX = XOR of the 8 data bits, inverted when PARITY_ODD = 1.
- STOP:
  - TX = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the final cycle, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- FIFO boundaries:
  - A push and a pop on the same edge leave the count unchanged.
  - Pushes to a full FIFO are impossible because TX_READY is low.
  - There is no bypass: a byte pushed into an empty FIFO is popped on the following edge.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset, including mid-frame:
  - State = IDLE, TX = 1, BUSY = 0, FIFO_COUNT = 0, and pointers, baud counter and bit counter all cleared.
  - TX_READY = 1 from the first edge after reset. Queued bytes are discarded and a partial frame is truncated to idle-high.

## Timing
- A byte accepted at edge k into an empty FIFO while the FSM is in IDLE produces the TX falling edge at edge k+1.
- BUSY rises at edge k+1.
- Frame length is (1 + 8 + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 when parity is compiled in. 8N1 at default parameters is 52080 cycles.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop-bit cycle.
- BUSY falls on the edge the FSM enters IDLE with the FIFO empty.
- FIFO_COUNT updates on the edge of the push or pop.

## Configuration
- UART_TX_PARITY_EN:
  - Defined: the PARITY state is compiled in, frames carry a parity bit after d7, and PARITY_ODD selects its sense.
  - Undefined: the PARITY state and its logic are removed, frames are 8N STOP_BITS, and PARITY_ODD has no effect.

## Test plan
- Single byte, CLKS_PER_BIT = 16, 8N1: push 0x41 -> sample TX mid-bit and read 0,1,0,0,0,0,0,1,0,1, with 16 cycles per bit, TX low exactly 1 cycle after accept, and BUSY low 160 cycles after the TX falling edge.
- Burst: push 0x55, 0xAA, 0x00, 0xFF, 0x3C back-to-back with FIFO_DEPTH = 4 -> TX_READY low once the count reaches 4 while frame 1 is on the line. All 5 bytes are sent in order with no idle gap and a total line-busy time of 5 × 160 cycles.
- Parity with UART_TX_PARITY_EN defined: 0x41 with PARITY_ODD = 0 -> parity bit 0. The same byte with PARITY_ODD = 1 -> parity bit 1, and the frame is 11 bits long.
- Reset mid-frame: assert RESET for 1 cycle during data bit 3 with 2 bytes queued -> TX = 1, FIFO_COUNT = 0 and BUSY = 0 after the edge, and no further frames are sent.
- Default parameters with a loopback of TX into the board receiver: push 0x41 -> DATA_OUT = 0x41. Each bit lasts 5208 cycles (104.16 µs at 20 ns).
- STOP_BITS = 2, CLKS_PER_BIT = 16: two back-to-back bytes -> 32 high cycles between the last data bit of byte 1 and the start bit of byte 2.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: FIFO-buffered 8-bit UART transmitter (LSB first, 1 or 2 stop bits).
// Define UART_TX_PARITY_EN to add a parity bit after d7 (sense chosen by PARITY_ODD).
module uart_frame_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX,
  output logic       BUSY,
  output logic [4:0] FIFO_COUNT
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  DEPTH5    = 5'(FIFO_DEPTH);
  localparam logic        STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  state_t        r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_cnt;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  state_t        w_state_next;
  logic [15:0]   w_baud_next;
  logic [2:0]    w_bit_next;
  logic          w_stop_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;
  logic          w_pop;
  logic          w_push;
  logic          w_nempty;
  logic          w_baud_end;
  logic [7:0]    w_head;

  assign TX_READY   = (r_count < DEPTH5);
  assign TX         = r_tx;
  assign BUSY       = r_busy;
  assign FIFO_COUNT = r_count;

  assign w_push     = TX_VALID && TX_READY;
  assign w_nempty   = (r_count != 5'd0);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_head     = r_mem[r_rd_ptr];

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge CLK) begin
    if (RESET)
      r_parity <= 1'b0;
    else if (w_pop)
      r_parity <= (^w_head) ^ PARITY_ODD;
  end
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  // Storage has no reset so it maps onto plain RAM; only pointers/count are cleared.
  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= TX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_bit_cnt  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_shift    <= 8'd0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_cnt  <= w_bit_next;
      r_stop_cnt <= w_stop_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      // Uses the pre-edge count so a push into an idle, empty FIFO raises BUSY with the start bit.
      r_busy     <= (w_state_next != S_IDLE) || w_nempty;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_cnt;
    w_stop_next  = r_stop_cnt;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_nempty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_baud_next  = 16'd0;
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_baud_next  = 16'd0;
          w_bit_next   = 3'd0;
          w_tx_next    = r_shift[0];
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_next = 16'd0;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_tx_next    = r_parity;
            w_state_next = S_PARITY;
`else
            w_tx_next    = 1'b1;
            w_stop_next  = 1'b0;
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next   = r_bit_cnt + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_end) begin
          w_baud_next  = 16'd0;
          w_tx_next    = 1'b1;
          w_stop_next  = 1'b0;
          w_state_next = S_STOP;
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_next = 16'd0;
          if (r_stop_cnt == STOP_LAST) begin
            // Chain straight into the next start bit when more bytes are queued.
            if (w_nempty) begin
              w_pop        = 1'b1;
              w_shift_next = w_head;
              w_tx_next    = 1'b0;
              w_state_next = S_START;
            end else begin
              w_tx_next    = 1'b1;
              w_state_next = S_IDLE;
            end
          end else begin
            w_stop_next = 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 16'd1;
        end
      end
      default: begin
        w_tx_next    = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule
